full_adder_cell: RTL and testbench
==================================

FULL_ADDER_CELL -- requirements
Module: full_adder_cell

Interface
REQ-001 Parameter REGISTER_OUTPUTS, default 0: 0 = registered outputs held at reset value; 1 = registered outputs updated every clock.
REQ-002 Port list, in this order:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- first_term  input  1  addend bit A.
- second_term  input  1  addend bit B.
- carry_in  input  1  carry from the previous bit position.
- sum_out  output  1  combinational sum bit.
- carry_out  output  1  combinational carry to the next bit position.
- propagate_out  output  1  combinational propagate, A XOR B.
- generate_out  output  1  combinational generate, A AND B.
- sum_q  output  1  registered sum bit.
- carry_q  output  1  registered carry bit.
REQ-003 The block shall have exactly one clock (clk) and one reset (reset); reset shall be asynchronous and active-high.

Function
REQ-004 sum_out shall equal first_term XOR second_term XOR carry_in, with zero-cycle latency.
REQ-005 carry_out shall equal (first_term AND second_term) OR (carry_in AND (first_term XOR second_term)), with zero-cycle latency.
REQ-006 sum_out and carry_out shall have no clock or reset dependency, so cells can be chained into a ripple-carry adder with a combinational carry path.
REQ-007 {carry_out, sum_out} read as a 2-bit unsigned value shall equal first_term + second_term + carry_in for all 8 input combinations.
REQ-008 propagate_out shall be first_term XOR second_term.
REQ-009 generate_out shall be first_term AND second_term.
REQ-010 generate_out and propagate_out shall never both be 1.
REQ-011 With REGISTER_OUTPUTS=1:
- on each rising edge of clk with reset low, sum_q shall load sum_out and carry_q shall load carry_out;
- latency is one cycle.
REQ-012 With REGISTER_OUTPUTS=0, sum_q and carry_q shall hold 0 at all times.
REQ-013 Unknown (X/Z) inputs are outside the defined operating range; outputs for them are unspecified.

Reset
REQ-014 While reset is high, sum_q and carry_q shall be 0, taking effect immediately without waiting for a clk edge.
REQ-015 Reset shall not affect sum_out, carry_out, propagate_out or generate_out.
REQ-016 On the first rising clk edge after reset deasserts, sum_q and carry_q shall capture the current combinational result.
REQ-017 If reset asserts mid-operation, sum_q and carry_q shall clear asynchronously; any capture pending on the same edge shall be discarded.

Structure
REQ-018 No shared package is required; the block has no typedefs and no shared constants.
REQ-019 The block shall be a single leaf module with no sub-modules.
REQ-020 The block shall serve as the per-bit cell of a WIDTH-parameterised ripple-carry adder:
- bit 0 carry_in is driven by the adder's carry-in;
- each carry_out feeds the next bit's carry_in;
- the final cell's carry_out is the adder's carry-out.

Verification
REQ-021 Exhaustive sweep of all 8 combinations of (first_term, second_term, carry_in) -> {carry_out, sum_out} equals the arithmetic sum (e.g. 1,1,1 -> carry_out=1, sum_out=1; 1,0,0 -> 0,1; 0,0,0 -> 0,0).
REQ-022 Inputs 1,1,0 -> generate_out=1, propagate_out=0; inputs 1,0,x -> generate_out=0, propagate_out=1.
REQ-023 REGISTER_OUTPUTS=1, inputs 0,1,1, one clk edge -> sum_q=0, carry_q=1; inputs changed to 1,0,0 before the next edge -> sum_q=1, carry_q=0 after that edge.
REQ-024 Reset asserted between clock edges while sum_q=1 -> sum_q=0 and carry_q=0 immediately; combinational outputs unchanged throughout.
REQ-025 Eight cells chained as an 8-bit ripple adder, 0xFF + 0x01 with carry_in=0 -> sum 0x00, final carry_out=1.
REQ-026 Eight cells chained as an 8-bit ripple adder, 0x5A + 0x25 with carry_in=1 -> sum 0x80, final carry_out=0.

Source files
------------

// File: rtl/full_adder_cell_pkg.sv
// Bit-level add helpers for the full-adder cell; a single evaluation point
// keeps the sum/carry/propagate/generate terms consistent with each other.
package full_adder_cell_pkg;

  // Returns {carry, sum} for a single bit position.
  function automatic logic [1:0] fa_eval(input logic a, input logic b, input logic c);
    logic p;
    p = a ^ b;
    return {(a & b) | (c & p), p ^ c};
  endfunction

  function automatic logic fa_propagate(input logic a, input logic b);
    return a ^ b;
  endfunction

  function automatic logic fa_generate(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder with combinational sum/carry/propagate/generate and an
// optional registered copy of {carry, sum}; usable as a ripple-carry cell.
module full_adder_cell
  import full_adder_cell_pkg::*;
#(
  parameter int REGISTER_OUTPUTS = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic first_term,
  input  logic second_term,
  input  logic carry_in,
  output logic sum_out,
  output logic carry_out,
  output logic propagate_out,
  output logic generate_out,
  output logic sum_q,
  output logic carry_q
);

  localparam logic REG_EN = (REGISTER_OUTPUTS != 0);

  logic [1:0] add_p0;
  logic       sum_p1;
  logic       carry_p1;

  // Stage p0: purely combinational, no clock or reset in the carry path.
  assign add_p0        = fa_eval(first_term, second_term, carry_in);
  assign sum_out       = add_p0[0];
  assign carry_out     = add_p0[1];
  assign propagate_out = fa_propagate(first_term, second_term);
  assign generate_out  = fa_generate(first_term, second_term);

  // Stage p1: registered copy; constant zero when registering is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_p1   <= 1'b0;
      carry_p1 <= 1'b0;
    end else begin
      sum_p1   <= REG_EN & add_p0[0];
      carry_p1 <= REG_EN & add_p0[1];
    end
  end

  assign sum_q   = sum_p1;
  assign carry_q = carry_p1;

endmodule

// File: tb/tb_full_adder_cell.sv
// Scoreboard bench for full_adder_cell: registered and unregistered cells
// plus an 8-bit ripple-carry chain built from unregistered cells.
module tb_full_adder_cell;

  logic clk = 1'b0;
  logic reset;
  logic a, b, ci;
  logic s1, c1, p1, g1, sq1, cq1;
  logic s0, c0, p0, g0, sq0, cq0;

  logic [7:0] ra, rb, rsum, rp, rg, rsq, rcq;
  logic       rcin;
  logic [8:0] rc;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] comb_q[$];
  logic [15:0] reg_q[$];

  always #5 clk = ~clk;

  full_adder_cell #(.REGISTER_OUTPUTS(1)) dut_reg (
    .clk(clk), .reset(reset), .first_term(a), .second_term(b), .carry_in(ci),
    .sum_out(s1), .carry_out(c1), .propagate_out(p1), .generate_out(g1),
    .sum_q(sq1), .carry_q(cq1)
  );

  full_adder_cell #(.REGISTER_OUTPUTS(0)) dut_noreg (
    .clk(clk), .reset(reset), .first_term(a), .second_term(b), .carry_in(ci),
    .sum_out(s0), .carry_out(c0), .propagate_out(p0), .generate_out(g0),
    .sum_q(sq0), .carry_q(cq0)
  );

  assign rc[0] = rcin;
  for (genvar k = 0; k < 8; k++) begin : g_rip
    full_adder_cell #(.REGISTER_OUTPUTS(0)) u_cell (
      .clk(clk), .reset(reset), .first_term(ra[k]), .second_term(rb[k]),
      .carry_in(rc[k]), .sum_out(rsum[k]), .carry_out(rc[k+1]),
      .propagate_out(rp[k]), .generate_out(rg[k]), .sum_q(rsq[k]), .carry_q(rcq[k])
    );
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one input vector; push the combinational expectation and the
  // value the registered cell should hold after the next edge.
  task automatic apply_vec(input logic ia, input logic ib, input logic ic, input bit captures);
    int t;
    logic [1:0] t2;
    logic pe, ge;
    a = ia; b = ib; ci = ic;
    t  = int'(ia) + int'(ib) + int'(ic);
    t2 = t[1:0];
    pe = (ia != ib);
    ge = (ia == 1'b1) && (ib == 1'b1);
    comb_q.push_back({12'h000, t2, pe, ge});
    reg_q.push_back(captures ? {14'h0000, t2} : 16'h0000);
  endtask

  task automatic check_comb(input string tag);
    logic [15:0] e;
    #1;
    if (comb_q.size() == 0) begin
      chk({tag, "_empty"}, 16'h0001, 16'h0000);
    end else begin
      e = comb_q.pop_front();
      chk(tag, {12'h000, c1, s1, p1, g1}, e);
      chk({tag, "_r0"}, {12'h000, c0, s0, p0, g0}, e);
      chk({tag, "_pg"}, {15'h0000, g1 & p1}, 16'h0000);
    end
  endtask

  task automatic check_reg(input string tag);
    logic [15:0] e;
    if (reg_q.size() == 0) begin
      chk({tag, "_empty"}, 16'h0001, 16'h0000);
    end else begin
      e = reg_q.pop_front();
      chk(tag, {14'h0000, cq1, sq1}, e);
      chk({tag, "_off"}, {14'h0000, cq0, sq0}, 16'h0000);
    end
  endtask

  task automatic cycle(input logic ia, input logic ib, input logic ic, input bit captures, input string tag);
    @(negedge clk);
    apply_vec(ia, ib, ic, captures);
    check_comb({tag, "_comb"});
    @(posedge clk);
    #1;
    check_reg({tag, "_reg"});
  endtask

  task automatic rip(input logic [7:0] x, input logic [7:0] y, input logic cin);
    logic [8:0] e;
    logic [15:0] got;
    ra = x; rb = y; rcin = cin;
    e = {1'b0, x} + {1'b0, y} + {8'h00, cin};
    comb_q.push_back({7'h00, e});
    #1;
    got = {7'h00, rc[8], rsum};
    chk("ripple", got, comb_q.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    a = 1'b0; b = 1'b0; ci = 1'b0;
    ra = 8'h00; rb = 8'h00; rcin = 1'b0;
    #2;
    chk("rst_init", {14'h0000, cq1, sq1}, 16'h0000);

    // Reset held across an edge: registered outputs stay 0, comb unaffected.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "rst_hold");

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cycle(i[2], i[1], i[0], 1'b1, "sweep");
    end

    cycle(1'b1, 1'b1, 1'b0, 1'b1, "gen");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "prop");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "seq_a");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, "seq_b");

    // Mid-cycle asynchronous reset while sum_q is 1.
    chk("pre_rst", {14'h0000, cq1, sq1}, 16'h0001);
    #2;
    reset = 1'b1;
    comb_q.push_back({12'h000, 4'b0110});
    check_comb("rst_mid_comb");
    chk("rst_mid", {14'h0000, cq1, sq1}, 16'h0000);

    cycle(1'b1, 1'b1, 1'b1, 1'b0, "rst_edge");

    @(negedge clk);
    reset = 1'b0;
    apply_vec(1'b1, 1'b1, 1'b0, 1'b1);
    check_comb("post_rst_comb");
    @(posedge clk);
    #1;
    check_reg("post_rst_reg");

    rip(8'hFF, 8'h01, 1'b0);
    rip(8'h5A, 8'h25, 1'b1);
    rip(8'h00, 8'h00, 1'b1);
    rip(8'hFF, 8'hFF, 1'b1);
    for (int j = 0; j < 6; j++) begin
      rip(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
